clock_reset_sequencer: RTL
==========================

# clock_reset_sequencer

Sequences clock enable and reset release for the system clock domain driven by the platform PLL wrapper. It waits for PLL lock and a stabilisation interval, then releases NUM_DOMAIN per-domain resets in a fixed order, spaced STAGE_GAP cycles apart. It re-asserts all resets on lock loss or a software reset request. It sits between the PLL clock wrapper and the platform reset tree, clocked by `clk_system`.

## Interface
- NUM_DOMAIN, 3: number of sequenced reset outputs (1..8).
- STABLE_CYCLES, 16: cycles lock must stay high before release begins (>=1).
- STAGE_GAP, 4: cycles between successive domain releases (>=1).
- HOLD_CYCLES, 8: cycles all resets are held after a software reset request (>=1).
- clk  input  1  system clock (PLL output).
- rstnn  input  1  asynchronous active-low reset.
- pll_locked  input  1  raw PLL lock; asynchronous to clk.
- sw_reset_req  input  1  single-cycle request to re-run the reset sequence without waiting for lock.
- clk_enable  output  1  enable for downstream clock gates.
- domain_rstnn  output  NUM_DOMAIN  active-low per-domain resets; bit 0 is released first.
- ready  output  1  high only in RUN.
- state  output  3  current FSM state code.
- lock_loss_count  output  8  saturating count of lock losses seen in RELEASE, RUN or HOLD.

## Operation
- pll_locked passes through a 2-flop synchronizer, giving lock_s. lock_s follows pll_locked by 2 clk edges. Both flops reset to 0.
- State codes: WAIT_LOCK=0, STABILIZE=1, RELEASE=2, RUN=3, HOLD=4. All other codes go to WAIT_LOCK.
- One down-counter `cnt` is shared by all states. Its width is clog2(max(STABLE_CYCLES,STAGE_GAP,HOLD_CYCLES))+1. A domain index `idx` has width clog2(NUM_DOMAIN)+1.
- WAIT_LOCK: clk_enable=0 and all domain_rstnn=0. When lock_s=1, go to STABILIZE and load cnt=STABLE_CYCLES-1.
- STABILIZE:
  - If lock_s=0, go to WAIT_LOCK.
  - Otherwise, if cnt=0, go to RELEASE, load cnt=STAGE_GAP-1, clear idx.
  - Otherwise decrement cnt.
- RELEASE:
  - clk_enable=1 from the first RELEASE cycle.
  - When cnt=0: set domain_rstnn[idx]=1, increment idx, reload cnt=STAGE_GAP-1.
  - Released bits stay 1.
  - After bit NUM_DOMAIN-1 is released, go to RUN on the same edge.
- RUN: ready=1. Holds until lock loss or sw_reset_req.
- HOLD: clk_enable stays 1 and all domain_rstnn=0. When cnt reaches 0, go to RELEASE with cnt=STAGE_GAP-1 and idx=0. STABILIZE is skipped.
- Priority in every state: lock loss (lock_s=0) > sw_reset_req > normal progression.
- Lock loss in RELEASE, RUN or HOLD:
  - On the next edge, go to WAIT_LOCK: clk_enable=0, all domain_rstnn=0, ready=0.
  - lock_loss_count increments by 1 and saturates at 255.
- sw_reset_req:
  - In RELEASE or RUN with lock_s=1: go to HOLD with cnt=HOLD_CYCLES-1 and all domain_rstnn=0.
  - In HOLD: restarts the hold count.
  - Ignored in WAIT_LOCK and STABILIZE.

## Timing
- Reset values (rstnn=0, asynchronous): state=WAIT_LOCK, clk_enable=0, domain_rstnn=all 0, ready=0, lock_loss_count=0, cnt=0, idx=0, synchronizer=0.
- All outputs are registered and change only on rising clk edges. There is no combinational path from any input to any output.
- Let E0 be the edge at which lock_s is first sampled high in WAIT_LOCK:
  - STABILIZE at E0.
  - RELEASE entry at E0+STABLE_CYCLES, with clk_enable=1.
  - domain_rstnn[k] rises at E0+STABLE_CYCLES+STAGE_GAP*(k+1).
  - RUN and ready=1 coincide with the last bit's rise.
- Lock loss to outputs deasserted: 1 edge after lock_s falls, which is 3 edges after pll_locked falls.
- sw_reset_req in RUN at edge S:
  - resets asserted and ready=0 at S.
  - RELEASE at S+HOLD_CYCLES.
  - domain 0 released at S+HOLD_CYCLES+STAGE_GAP.
- Lock lost while sw_reset_req is high on the same edge: WAIT_LOCK, and the counter increments once.
- rstnn asserted mid-sequence returns everything to reset values immediately. The sequence resumes only after rstnn deasserts and the full lock and stabilise path completes.

## Test plan
- Params 3/16/4/8; pll_locked rises so lock_s is high at E0=10 -> state=1 at 10, clk_enable=1 at 26, domain_rstnn=001 at 30, 011 at 34, 111 at 38, ready=1 at 38.
- lock_s drops for 1 cycle at E0+8 during STABILIZE -> state=0, domain_rstnn=000, lock_loss_count stays 0; after relock, STABILIZE restarts the full 16 cycles.
- In RUN, pll_locked falls -> 3 edges later clk_enable=0, domain_rstnn=000, ready=0, lock_loss_count=1; repeat 300 times -> count holds at 255.
- sw_reset_req pulse at edge 50 in RUN -> domain_rstnn=000 at 50, clk_enable stays 1, state=2 at 58, domain_rstnn=001 at 62, 111 at 70, ready=1 at 70.
- sw_reset_req in RELEASE after domain_rstnn=001 -> resets 000, HOLD for 8 cycles, then sequence restarts from bit 0; a second pulse during HOLD extends HOLD by 8 cycles from that edge.
- rstnn pulsed low while domain_rstnn=011 -> all outputs immediately 0, state=0, counter 0; with pll_locked held high, the full sequence re-runs with the same timing as scenario 1.

Source files
------------

// File: rtl/clock_reset_sequencer.sv
// Sequences clock enable and per-domain reset release for the system clock domain.
// Waits for a synchronized, stable PLL lock, then releases domain resets one at a time.
module clock_reset_sequencer #(
    parameter int NUM_DOMAIN    = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int STAGE_GAP     = 4,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    output logic                  clk_enable,
    output logic [NUM_DOMAIN-1:0] domain_rstnn,
    output logic                  ready,
    output logic [2:0]            state,
    output logic [7:0]            lock_loss_count
);

    localparam int MAX_AB    = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int MAX_CYCLE = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int CW        = $clog2(MAX_CYCLE) + 1;
    localparam int IW        = $clog2(NUM_DOMAIN) + 1;

    localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_DOMAIN - 1);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABILIZE = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] HOLD      = 3'd4;

    logic [1:0]            sync_q;
    logic                  lock_s;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DOMAIN-1:0] rst_q, rst_d;
    logic                  en_q, en_d;
    logic                  ready_q, ready_d;
    logic [7:0]            loss_q, loss_d;

    // pll_locked is asynchronous to clk; two flops before anything looks at it.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        en_d    = en_q;
        loss_d  = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                en_d  = 1'b0;
                rst_d = '0;
                if (lock_s) begin
                    state_d = STABILIZE;
                    cnt_d   = STABLE_LOAD;
                end
            end

            STABILIZE: begin
                en_d  = 1'b0;
                rst_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = RELEASE;
                    cnt_d   = GAP_LOAD;
                    idx_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RELEASE, RUN, HOLD: begin
                // Lock loss beats a software request, which beats normal progression.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    en_d    = 1'b0;
                    rst_d   = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (sw_reset_req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    rst_d   = '0;
                    en_d    = 1'b1;
                end else if (state_q == RELEASE) begin
                    en_d = 1'b1;
                    if (cnt_q == '0) begin
                        rst_d = rst_q | (NUM_DOMAIN'(1) << idx_q);
                        idx_d = idx_q + IW'(1);
                        cnt_d = GAP_LOAD;
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else if (state_q == HOLD) begin
                    en_d  = 1'b1;
                    rst_d = '0;
                    if (cnt_q == '0) begin
                        state_d = RELEASE;
                        cnt_d   = GAP_LOAD;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                en_d    = 1'b0;
                rst_d   = '0;
            end
        endcase

        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            loss_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    assign clk_enable      = en_q;
    assign domain_rstnn    = rst_q;
    assign ready           = ready_q;
    assign state           = state_q;
    assign lock_loss_count = loss_q;

endmodule
